// File: rtl/mem_pkg.sv
// Shared encodings for the load/store stage: access sizes, fault causes, FSM states.
package mem_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_LD_MIS  = 2'd1;
  localparam logic [1:0] CAUSE_ST_MIS  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;

  function automatic int size_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store replication, misalignment,
// and load extract with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                 size,
  input  logic                       uns,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            sdata,
  input  logic [XLEN-1:0]            rdata,
  output logic                       misaligned,
  output logic [XLEN/8-1:0]          be,
  output logic [XLEN-1:0]            wdata,
  output logic [XLEN-1:0]            ldata
);
  localparam int NB = XLEN / 8;

  int              nbytes;
  logic [XLEN-1:0] shifted;
  logic            sgn;

  always_comb begin
    nbytes  = size_bytes(size);
    shifted = rdata >> {offset, 3'b000};
    sgn     = shifted[XLEN-1];
    be      = '0;
    wdata   = '0;
    ldata   = '0;
    // a size wider than the datapath can never be aligned
    misaligned = ((int'(offset) & (nbytes - 1)) != 0) || (nbytes > NB);
    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= int'(offset)) && (i < int'(offset) + nbytes);
      wdata[i*8 +: 8] = sdata[(i % nbytes)*8 +: 8];
    end
    case (size)
      SZ_B:    sgn = shifted[7];
      SZ_H:    sgn = shifted[15];
      SZ_W:    sgn = shifted[31];
      default: sgn = shifted[XLEN-1];
    endcase
    for (int j = 0; j < XLEN; j++)
      ldata[j] = (j < nbytes*8) ? shifted[j] : (sgn & ~uns);
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: registered pass-through for ALU ops, req/ack data-memory
// access with stall, misalignment faults and a bus-timeout fault.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic                rd_i,
  input  logic                wr_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [XLEN-1:0]     sdata_i,
  input  logic                wb_en_i,
  input  logic [REG_AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  output logic                stall_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic [XLEN/8-1:0]   dmem_be_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  input  logic                dmem_ack_i,
  input  logic [XLEN-1:0]     dmem_rdata_i,
  output logic                wb_valid_o,
  output logic                wb_en_o,
  output logic [REG_AW-1:0]   wb_addr_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic                fault_o,
  output logic [1:0]          fault_cause_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e             state;
  logic [CW-1:0]      wait_cnt;
  logic               ld_q, uns_q, wb_en_q;
  logic [1:0]         size_q;
  logic [OW-1:0]      off_q;
  logic [REG_AW-1:0]  wb_addr_q;

  logic               in_access, is_mem, mis;
  logic [1:0]         al_size;
  logic               al_uns;
  logic [OW-1:0]      al_off;
  logic [NB-1:0]      al_be;
  logic [XLEN-1:0]    al_wdata, al_ldata;

  assign in_access = (state == S_ACCESS);
  assign stall_o   = in_access;
  assign is_mem    = rd_i | wr_i;

  // one aligner: steers the incoming op in IDLE, extracts load data in ACCESS
  assign al_size = in_access ? size_q : size_i;
  assign al_uns  = in_access ? uns_q  : unsigned_i;
  assign al_off  = in_access ? off_q  : addr_i[OW-1:0];

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size       (al_size),
    .uns        (al_uns),
    .offset     (al_off),
    .sdata      (sdata_i),
    .rdata      (dmem_rdata_i),
    .misaligned (mis),
    .be         (al_be),
    .wdata      (al_wdata),
    .ldata      (al_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      ld_q          <= 1'b0;
      uns_q         <= 1'b0;
      wb_en_q       <= 1'b0;
      size_q        <= 2'd0;
      off_q         <= '0;
      wb_addr_q     <= '0;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= '0;
      dmem_be_o     <= '0;
      dmem_wdata_o  <= '0;
      wb_valid_o    <= 1'b0;
      wb_en_o       <= 1'b0;
      wb_addr_o     <= '0;
      wb_data_o     <= '0;
      fault_o       <= 1'b0;
      fault_cause_o <= CAUSE_NONE;
    end else begin
      wb_valid_o    <= 1'b0;
      wb_en_o       <= 1'b0;
      wb_addr_o     <= '0;
      wb_data_o     <= '0;
      fault_o       <= 1'b0;
      fault_cause_o <= CAUSE_NONE;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              wb_valid_o <= 1'b1;
              wb_en_o    <= wb_en_i;
              wb_addr_o  <= wb_addr_i;
              wb_data_o  <= wb_data_i;
            end else if (mis) begin
              wb_valid_o    <= 1'b1;
              fault_o       <= 1'b1;
              fault_cause_o <= wr_i ? CAUSE_ST_MIS : CAUSE_LD_MIS;
            end else begin
              state        <= S_ACCESS;
              wait_cnt     <= '0;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= wr_i;
              dmem_addr_o  <= addr_i & ~XLEN'(NB - 1);
              dmem_be_o    <= al_be;
              dmem_wdata_o <= al_wdata;
              ld_q         <= ~wr_i;
              size_q       <= size_i;
              uns_q        <= unsigned_i;
              off_q        <= addr_i[OW-1:0];
              wb_en_q      <= wb_en_i;
              wb_addr_q    <= wb_addr_i;
            end
          end
        end
        S_ACCESS: begin
          if (dmem_ack_i || wait_cnt == CW'(MAX_WAIT - 1)) begin
            state        <= S_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b1;
            // ack on the final allowed cycle still completes normally
            if (dmem_ack_i) begin
              if (ld_q) begin
                wb_en_o   <= wb_en_q;
                wb_addr_o <= wb_addr_q;
                wb_data_o <= al_ldata;
              end
            end else begin
              fault_o       <= 1'b1;
              fault_cause_o <= CAUSE_TIMEOUT;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
